// File: rtl/ram_lvt_pkg.sv
// Shared sizing for the live-value-table multi-port RAM: default port counts,
// widths, conflict counter width and the LVT index-width helper.
package ram_lvt_pkg;

  localparam int DEF_NW     = 2;
  localparam int DEF_NR     = 8;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // One LVT bit is still needed when only a single writer exists.
  function automatic int lvt_width(input int nw);
    return (nw <= 1) ? 1 : $clog2(nw);
  endfunction

  localparam int DEF_LVT_W = lvt_width(DEF_NW);

endpackage

// File: rtl/ram_1R1W.sv
// Simple dual-port RAM bank: one synchronous write port, one synchronous
// read port, read-first on a same-address collision.
module ram_1R1W #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset so it can map onto block RAM; its
  // contents are undefined after power-up. Non-blocking writes also make the
  // read return the old word when raddr == waddr in the same cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_lvt_nrnw.sv
// NW-write / NR-read RAM built from NW x NR 1R1W banks; a live value table
// remembers which write port last wrote each address and steers the read mux.
module ram_lvt_nrnw
  import ram_lvt_pkg::*;
#(
  parameter int NW     = DEF_NW,
  parameter int NR     = DEF_NR,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NW-1:0]        w_enb,
  input  logic [NW*ADDR_W-1:0] w_addr,
  input  logic [NW*DATA_W-1:0] w_din,
  input  logic [NR*ADDR_W-1:0] r_addr,
  output logic [NR*DATA_W-1:0] r_dout,
  output logic                 w_conflict,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int LVT_W = lvt_width(NW);
  localparam int DEPTH = 2**ADDR_W;

  logic [LVT_W-1:0]  lvt     [DEPTH];
  logic [LVT_W-1:0]  rd_sel  [NR];
  logic [DATA_W-1:0] bank_q  [NW][NR];
  logic              rd_vld;
  logic              conflict_c;
  logic [NW-1:0]     wr_en;

  // Banks are not reset, so writes must be blocked on edges seen under reset.
  assign wr_en = rst ? w_enb : '0;

  for (genvar gi = 0; gi < NW; gi++) begin : g_wr
    for (genvar gj = 0; gj < NR; gj++) begin : g_rd
      ram_1R1W #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_bank (
        .clk   (clk),
        .we    (wr_en[gi]),
        .waddr (w_addr[gi*ADDR_W +: ADDR_W]),
        .wdata (w_din[gi*DATA_W +: DATA_W]),
        .raddr (r_addr[gj*ADDR_W +: ADDR_W]),
        .rdata (bank_q[gi][gj])
      );
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NW; i++) begin
      for (int k = i + 1; k < NW; k++) begin
        if (w_enb[i] && w_enb[k] &&
            (w_addr[i*ADDR_W +: ADDR_W] == w_addr[k*ADDR_W +: ADDR_W]))
          conflict_c = 1'b1;
      end
    end
  end

  // Ascending port order: the last non-blocking update wins, so the
  // highest-index writer owns a contested address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (w_enb[i]) lvt[w_addr[i*ADDR_W +: ADDR_W]] <= LVT_W'(i);
      end
    end
  end

  // LVT lookup is registered alongside the bank read so both refer to cycle t.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld <= 1'b0;
      for (int j = 0; j < NR; j++) rd_sel[j] <= '0;
    end else begin
      rd_vld <= 1'b1;
      for (int j = 0; j < NR; j++) rd_sel[j] <= lvt[r_addr[j*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_conflict   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      w_conflict <= conflict_c;
      if (conflict_c && (conflict_cnt != CNT_MAX))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Bank outputs are not reset; rd_vld forces zero until a post-reset read lands.
  always_comb begin
    r_dout = '0;
    for (int j = 0; j < NR; j++) begin
      r_dout[j*DATA_W +: DATA_W] = rd_vld ? bank_q[rd_sel[j]][j] : '0;
    end
  end

endmodule

// File: tb/tb_ram_lvt_nrnw.sv
// Randomised scoreboard bench for ram_lvt_nrnw (NW=4, NR=3) against a flat
// memory model with highest-index write priority and a port-0 shadow for reset.
module tb_ram_lvt_nrnw;

  localparam int NW    = 4;
  localparam int NR    = 3;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NW-1:0]      w_enb = '0;
  logic [NW*AW-1:0]   w_addr = '0;
  logic [NW*DW-1:0]   w_din = '0;
  logic [NR*AW-1:0]   r_addr = '0;
  logic [NR*DW-1:0]   r_dout;
  logic               w_conflict;
  logic [15:0]        conflict_cnt;

  ram_lvt_nrnw #(
    .NW     (NW),
    .NR     (NR),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_enb        (w_enb),
    .w_addr       (w_addr),
    .w_din        (w_din),
    .r_addr       (r_addr),
    .r_dout       (r_dout),
    .w_conflict   (w_conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    ok;
    logic             conf;
    logic [15:0]      cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_on = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: observable memory plus what the port-0 banks hold.
  logic [DW-1:0] mem    [DEPTH];
  bit            mem_ok [DEPTH];
  logic [DW-1:0] p0_mem [DEPTH];
  bit            p0_ok  [DEPTH];
  int            n_conf = 0;

  // Per-cycle stimulus set by the scenarios, applied by step().
  logic [NW-1:0] en_v;
  logic [AW-1:0] wa_v [NW];
  logic [DW-1:0] wd_v [NW];
  logic [AW-1:0] ra_v [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  // Called just after a rising edge; applies inputs for the next edge.
  task automatic step();
    exp_t e;
    bit   conf;
    e = '0;
    w_enb = en_v;
    for (int i = 0; i < NW; i++) begin
      w_addr[i*AW +: AW] = wa_v[i];
      w_din[i*DW +: DW]  = wd_v[i];
    end
    for (int j = 0; j < NR; j++) begin
      r_addr[j*AW +: AW] = ra_v[j];
      e.ok[j]            = mem_ok[ra_v[j]];
      e.data[j*DW +: DW] = mem[ra_v[j]];
    end
    conf = 1'b0;
    for (int i = 0; i < NW; i++)
      for (int k = i + 1; k < NW; k++)
        if (en_v[i] && en_v[k] && wa_v[i] == wa_v[k]) conf = 1'b1;
    if (conf) n_conf++;
    for (int i = 0; i < NW; i++) begin
      if (en_v[i]) begin
        mem[wa_v[i]]    = wd_v[i];
        mem_ok[wa_v[i]] = 1'b1;
        if (i == 0) begin
          p0_mem[wa_v[i]] = wd_v[i];
          p0_ok[wa_v[i]]  = 1'b1;
        end
      end
    end
    e.conf = conf;
    e.cnt  = (n_conf > 65535) ? 16'hFFFF : n_conf[15:0];
    sb.push_back(e);
    @(posedge clk);
    mon_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    en_v = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int j = 0; j < NR; j++)
      check($sformatf("%s r_dout[%0d]", tag, j), r_dout[j*DW +: DW], 32'h0);
    check({tag, " w_conflict"}, {31'h0, w_conflict}, 32'h0);
    check({tag, " conflict_cnt"}, {16'h0, conflict_cnt}, 32'h0);
  endtask

  // Called after step(); pulses reset mid-cycle, or holds it across an edge
  // during which port 0 attempts a write that must be ignored.
  task automatic do_reset(input bit span_edge);
    w_enb = '0;
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    rst    = 1'b0;
    #1;
    check_reset_outputs("reset");
    if (span_edge) begin
      w_enb              = 4'b0001;
      w_addr[0 +: AW]    = AW'(9);
      w_din[0 +: DW]     = 32'hDEAD_0009;
      @(posedge clk);
      #1;
      check_reset_outputs("reset_edge");
      w_enb = '0;
    end else begin
      #1;
    end
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]    = p0_mem[a];
      mem_ok[a] = p0_ok[a];
    end
    n_conf = 0;
    sb.delete();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (sb.size() == 0) begin
          check("scoreboard underflow", 32'h1, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          for (int j = 0; j < NR; j++)
            if (mon_e.ok[j])
              check($sformatf("r_dout[%0d]", j), r_dout[j*DW +: DW], mon_e.data[j*DW +: DW]);
          check("w_conflict", {31'h0, w_conflict}, {31'h0, mon_e.conf});
          check("conflict_cnt", {16'h0, conflict_cnt}, {16'h0, mon_e.cnt});
        end
      end
    end
  end

  initial begin : watchdog
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int a = 0; a < DEPTH; a++) begin
      mem_ok[a] = 1'b0;
      p0_ok[a]  = 1'b0;
      mem[a]    = '0;
      p0_mem[a] = '0;
    end
    en_v = '0;
    for (int i = 0; i < NW; i++) begin wa_v[i] = '0; wd_v[i] = '0; end
    for (int j = 0; j < NR; j++) ra_v[j] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;

    // Sequential writes from two ports: later writer owns the address.
    for (int j = 0; j < NR; j++) ra_v[j] = AW'(5);
    en_v = 4'b0001; wa_v[0] = AW'(5); wd_v[0] = 32'hAAAA_0001; step();
    en_v = 4'b0010; wa_v[1] = AW'(5); wd_v[1] = 32'hBBBB_0002; step();
    idle(); step(); step();

    // Same-cycle conflict at the top address: port 1 wins, counter 0 -> 1.
    for (int j = 0; j < NR; j++) ra_v[j] = AW'(13'h1FFF);
    en_v = 4'b0011;
    wa_v[0] = AW'(13'h1FFF); wd_v[0] = 32'h11;
    wa_v[1] = AW'(13'h1FFF); wd_v[1] = 32'h22;
    step();
    idle(); step(); step();

    // Read-first: read port 2 sees the old word in the write cycle.
    en_v = 4'b0001; wa_v[0] = AW'(7); wd_v[0] = 32'h33; step();
    ra_v[2] = AW'(7);
    en_v = 4'b0010; wa_v[1] = AW'(7); wd_v[1] = 32'h44; step();
    idle(); step(); step();

    // Random traffic over a small address window to force overlaps.
    for (int c = 0; c < 10000; c++) begin
      en_v = NW'($urandom);
      for (int i = 0; i < NW; i++) begin
        wa_v[i] = rnd_addr();
        wd_v[i] = $urandom;
      end
      for (int j = 0; j < NR; j++) ra_v[j] = rnd_addr();
      step();
    end
    idle(); step();

    // Back-to-back conflicts drive the counter into saturation.
    for (int c = 0; c < 65540; c++) begin
      en_v    = 4'b0011;
      wa_v[0] = rnd_addr();
      wa_v[1] = wa_v[0];
      wd_v[0] = $urandom;
      wd_v[1] = $urandom;
      for (int j = 0; j < NR; j++) ra_v[j] = rnd_addr();
      step();
    end
    idle(); step(); step();

    // Mid-cycle reset drops the LVT: addr 3 falls back to the port-0 bank.
    en_v = 4'b0001; wa_v[0] = AW'(3); wd_v[0] = 32'h66; step();
    en_v = 4'b0010; wa_v[1] = AW'(3); wd_v[1] = 32'h55; step();
    idle();
    for (int j = 0; j < NR; j++) ra_v[j] = AW'(3);
    step();
    do_reset(1'b0);
    step(); step();

    // Reset held across an edge must swallow a pending write.
    en_v = 4'b0001; wa_v[0] = AW'(9); wd_v[0] = 32'h9999; step();
    do_reset(1'b1);
    idle();
    for (int j = 0; j < NR; j++) ra_v[j] = AW'(9);
    step(); step();

    @(negedge clk);
    #1;
    check("scoreboard drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
